// File: rtl/vedic_mac_acc.sv
// Multiply-accumulate stage: streams 8-bit operand pairs through a Vedic 8x8 multiplier
// and emits one accumulated dot product per vector, with a sticky overflow flag.

module vedic_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // Urdhva-tiryagbhyam: each level combines four half-width partial products
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] mid;
    mid  = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
    mul2 = {1'b0, x[1] & y[1], 1'b0, x[0] & y[0]} + {1'b0, mid, 1'b0};
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0   = mul2(x[1:0], y[1:0]);
    q1   = mul2(x[3:2], y[1:0]);
    q2   = mul2(x[1:0], y[3:2]);
    q3   = mul2(x[3:2], y[3:2]);
    mul4 = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
  endfunction

  logic [7:0] r0, r1, r2, r3;

  always_comb begin
    r0 = mul4(a[3:0], b[3:0]);
    r1 = mul4(a[7:4], b[3:0]);
    r2 = mul4(a[3:0], b[7:4]);
    r3 = mul4(a[7:4], b[7:4]);
    p  = {8'b0, r0} + {4'b0, r1, 4'b0} + {4'b0, r2, 4'b0} + {r3, 8'b0};
  end

endmodule

module vedic_mac_acc #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain, StHold} state_e;

  state_e state_q, state_d;

  logic             accept;
  logic [7:0]       a_q, b_q;
  logic             last_q, s1_valid_q;
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q, count_next;
  logic             ovf_q, ovf_next, cnt_sat;
  logic [ACC_W:0]   sum;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;

  vedic_8x8 u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  always_comb begin
    in_ready   = (state_q == StIdle) || (state_q == StAccum);
    accept     = in_valid && in_ready;
    sum        = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod};
    cnt_sat    = &count_q;
    count_next = cnt_sat ? count_q : count_q + {{(CNT_W - 1){1'b0}}, 1'b1};
    ovf_next   = ovf_q | sum[ACC_W] | cnt_sat;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = in_last ? StDrain : StAccum;
      StAccum: if (accept && in_last) state_d = StDrain;
      StDrain: state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage 1: operand capture feeding the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      last_q     <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        a_q    <= in_a;
        b_q    <= in_b;
        last_q <= in_last;
      end
    end
  end

  // Stage 2: accumulate; the last beat moves the totals to the output and clears the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (s1_valid_q) begin
        if (last_q) begin
          out_data_q  <= sum[ACC_W-1:0];
          out_count_q <= count_next;
          out_ovf_q   <= ovf_next;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          count_q     <= '0;
          ovf_q       <= 1'b0;
        end else begin
          acc_q   <= sum[ACC_W-1:0];
          count_q <= count_next;
          ovf_q   <= ovf_next;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
